quad_paddle_input: RTL

//   Parametrised N-channel quadrature-encoder front end for pong paddle control; replaces ad-hoc per-player a/b handling.
//   Per channel: 2-FF synchroniser, debounce filter, Gray-code decoder, saturating paddle-position counter.

---
 rtl/pong_pkg.sv | 54 +++++
 rtl/quad_channel.sv | 157 +++++++++++++++
 rtl/quad_paddle_input.sv | 59 +++++
 3 files changed

// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
//   Shared definitions for the pong paddle input path.
//   - Gray-code state constants for a quadrature encoder, as {A,B}.
//   - Step encoding produced by the quadrature decoder.
//   - gray_step(): classifies one transition between two {A,B} states.
//   - clog2(): width helper for the debounce counters.
// ---------------------------------------------------------------------------
package pong_pkg;

    // Quadrature states as {A,B}; forward rotation visits them in this order.
    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_01 = 2'b01;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_10 = 2'b10;

    // STEP_ILL marks a double-bit transition, where the direction is unknowable.
    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_UP   = 2'b01,
        STEP_DN   = 2'b10,
        STEP_ILL  = 2'b11
    } step_t;

    // Number of bits needed to hold the values 0 .. value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Full (x4) decode of a single transition prev -> cur.
    function automatic step_t gray_step(input logic [1:0] prev, input logic [1:0] cur);
        step_t result;
        if (prev == cur) begin
            result = STEP_NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            result = STEP_ILL;
        end else begin
            case ({prev, cur})
                {QS_00, QS_01},
                {QS_01, QS_11},
                {QS_11, QS_10},
                {QS_10, QS_00}: result = STEP_UP;
                default:        result = STEP_DN;
            endcase
        end
        return result;
    endfunction

endpackage

// File: rtl/quad_channel.sv
// ---------------------------------------------------------------------------
// quad_channel
//   One quadrature encoder: 2-FF synchroniser, per-bit debounce filter,
//   registered Gray-code decoder and saturating paddle-position counter.
//
//   Build option: define QDEC_X4_EN to count every legal Gray transition;
//   otherwise only entries into state 00 count (10->00 = +1, 01->00 = -1).
//
//   Ports
//     clk32mhz  in   clock
//     reset     in   asynchronous, active-low
//     enc_a     in   encoder phase A (asynchronous pin)
//     enc_b     in   encoder phase B (asynchronous pin)
//     clear     in   synchronous recentre of pos and clear of err
//     pos       out  paddle position, POS_MIN..POS_MAX
//     moved     out  1-cycle pulse when pos changes value
//     dir       out  direction of last accepted step (1 = up)
//     err       out  sticky illegal-transition flag
// ---------------------------------------------------------------------------
module quad_channel
    import pong_pkg::*;
#(
    parameter int POS_W           = 5,
    parameter int POS_MIN         = 0,
    parameter int POS_MAX         = 28,
    parameter int POS_RESET       = 14,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic             clk32mhz,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clear,
    output logic [POS_W-1:0] pos,
    output logic             moved,
    output logic             dir,
    output logic             err
);

    localparam int               CNT_W    = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [POS_W-1:0] MIN_P    = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] MAX_P    = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] RESET_P  = POS_W'(POS_RESET);

    // Bit 1 carries phase A, bit 0 phase B throughout, matching QS_* constants.
    logic [1:0]            sync1_q,  sync1_d;
    logic [1:0]            sync2_q,  sync2_d;
    logic [1:0]            stable_q, stable_d;
    logic [1:0][CNT_W-1:0] cnt_q,    cnt_d;
    logic [1:0]            state_q,  state_d;
    logic [POS_W-1:0]      pos_q,    pos_d;
    logic                  moved_q,  moved_d;
    logic                  dir_q,    dir_d;
    logic                  err_q,    err_d;

    step_t raw_step;
    step_t step;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        sync1_d  = {enc_a, enc_b};
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;

        // Debounce: any bounce back to the stable level restarts the count.
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        // Decode compares the debounced level with the last decoded state, so
        // a change in stable_q produces exactly one step one edge later.
        raw_step = gray_step(state_q, stable_q);
`ifdef QDEC_X4_EN
        step = raw_step;
`else
        // x1: gray_step already yields UP for 10->00 and DN for 01->00.
        if (raw_step == STEP_ILL || stable_q == QS_00) begin
            step = raw_step;
        end else begin
            step = STEP_NONE;
        end
`endif

        state_d = stable_q;
        pos_d   = pos_q;
        moved_d = 1'b0;
        dir_d   = dir_q;
        err_d   = err_q;

        case (step)
            STEP_UP: begin
                dir_d = 1'b1;
                if (pos_q < MAX_P) begin
                    pos_d   = pos_q + 1'b1;
                    moved_d = 1'b1;
                end
            end
            STEP_DN: begin
                dir_d = 1'b0;
                if (pos_q > MIN_P) begin
                    pos_d   = pos_q - 1'b1;
                    moved_d = 1'b1;
                end
            end
            STEP_ILL: err_d = 1'b1;
            default:  ;
        endcase

        // Clear drops any step landing this cycle; decoder state still tracks
        // the input so nothing spurious is counted once clear drops.
        if (clear) begin
            pos_d   = RESET_P;
            moved_d = 1'b0;
            dir_d   = dir_q;
            err_d   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk32mhz or negedge reset) begin
        if (!reset) begin
            sync1_q  <= QS_00;
            sync2_q  <= QS_00;
            stable_q <= QS_00;
            cnt_q    <= '0;
            state_q  <= QS_00;
            pos_q    <= RESET_P;
            moved_q  <= 1'b0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            pos_q    <= pos_d;
            moved_q  <= moved_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
        end
    end

    assign pos   = pos_q;
    assign moved = moved_q;
    assign dir   = dir_q;
    assign err   = err_q;

endmodule

// File: rtl/quad_paddle_input.sv
// ---------------------------------------------------------------------------
// quad_paddle_input
//   N-channel quadrature-encoder front end for pong paddle control. Each
//   channel is an independent quad_channel; this level only packs/unpacks the
//   buses and fans out clear.
//
//   Build option: QDEC_X4_EN (x4 counting when defined, x1 otherwise).
//
//   Ports
//     clk32mhz  in   1                31.5 MHz pixel clock
//     reset     in   1                asynchronous, active-low
//     enc_a     in   CHANNELS         encoder phase A pins
//     enc_b     in   CHANNELS         encoder phase B pins
//     clear     in   1                recentre all positions, clear all err
//     pos       out  CHANNELS*POS_W   channel i at [i*POS_W +: POS_W]
//     moved     out  CHANNELS         1-cycle pulse when pos[i] changes
//     dir       out  CHANNELS         last accepted step direction, 1 = up
//     err       out  CHANNELS         sticky illegal-transition flag
// ---------------------------------------------------------------------------
module quad_paddle_input #(
    parameter int CHANNELS        = 2,
    parameter int POS_W           = 5,
    parameter int POS_MIN         = 0,
    parameter int POS_MAX         = 28,
    parameter int POS_RESET       = 14,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic                      clk32mhz,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enc_a,
    input  logic [CHANNELS-1:0]       enc_b,
    input  logic                      clear,
    output logic [CHANNELS*POS_W-1:0] pos,
    output logic [CHANNELS-1:0]       moved,
    output logic [CHANNELS-1:0]       dir,
    output logic [CHANNELS-1:0]       err
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        quad_channel #(
            .POS_W           (POS_W),
            .POS_MIN         (POS_MIN),
            .POS_MAX         (POS_MAX),
            .POS_RESET       (POS_RESET),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk32mhz (clk32mhz),
            .reset    (reset),
            .enc_a    (enc_a[g]),
            .enc_b    (enc_b[g]),
            .clear    (clear),
            .pos      (pos[g*POS_W +: POS_W]),
            .moved    (moved[g]),
            .dir      (dir[g]),
            .err      (err[g])
        );
    end

endmodule
